// File: rtl/debounce_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared types and constants for the debounce block.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    QUAL   = 1'b1
  } debounce_state_e;

  localparam int GlitchCntWidth = 8;

endpackage
`default_nettype wire

// File: rtl/debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debounce
// Purpose  : Debounces a synchronized level; emits rise/fall pulses.
//            Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt_o.
// Revision : 1.0 - initial release
// ============================================================================
module debounce
  import debounce_pkg::*;
#(
  parameter int   StableCycles = 4,
  parameter logic ResetLevel   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       din_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       busy_o
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GlitchCntWidth-1:0] glitch_cnt_o
`endif
);

  localparam int CntWidth = $clog2(StableCycles + 1);
  localparam logic [CntWidth-1:0] c_cnt_last = CntWidth'(StableCycles - 1);
  localparam logic [CntWidth-1:0] c_cnt_one  = CntWidth'(1);

  if (StableCycles < 1) begin : g_param_check
    $fatal(1, "debounce: StableCycles must be >= 1");
  end

  debounce_state_e     r_state, w_state_nxt;
  logic [CntWidth-1:0] r_cnt, w_cnt_nxt;
  logic                r_level, w_level_nxt;
  logic                r_rise, w_rise_nxt;
  logic                r_fall, w_fall_nxt;
  logic                w_differ;
  logic                w_glitch;

  assign w_differ = (din_i != r_level);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_glitch    = 1'b0;
    case (r_state)
      STABLE: begin
        if (!w_differ) begin
          w_cnt_nxt = '0;
        end else if (StableCycles == 1) begin
          w_level_nxt = din_i;
          w_rise_nxt  = din_i;
          w_fall_nxt  = ~din_i;
        end else begin
          w_state_nxt = QUAL;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      QUAL: begin
        if (w_differ) begin
          if (r_cnt == c_cnt_last) begin
            w_level_nxt = din_i;
            w_rise_nxt  = din_i;
            w_fall_nxt  = ~din_i;
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end else begin
          // Input fell back before qualifying: drop all accumulated credit.
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
          w_glitch    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_level <= ResetLevel;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign busy_o  = (r_state == QUAL);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GlitchCntWidth-1:0] r_glitch_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign glitch_cnt_o = r_glitch_cnt;
`else
  logic w_unused_glitch;
  assign w_unused_glitch = w_glitch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_debounce
// Purpose  : Randomized and directed bench for debounce against a sample-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce;

  localparam int c_ndut = 3;
  localparam int c_n  [c_ndut] = '{4, 1, 3};
  localparam bit c_rl [c_ndut] = '{1'b0, 1'b0, 1'b1};

  logic clk;
  logic rst_n;
  logic din   [c_ndut];
  logic level [c_ndut];
  logic rise  [c_ndut];
  logic fall  [c_ndut];
  logic busy  [c_ndut];
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gcnt [c_ndut];
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: samples differing from the accepted level since it last settled.
  bit m_hist [c_ndut][$];
  bit m_level [c_ndut];
  bit m_rise  [c_ndut];
  bit m_fall  [c_ndut];
  int m_glitch [c_ndut];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  debounce #(.StableCycles(4), .ResetLevel(1'b0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din[0]),
    .level_o(level[0]), .rise_o(rise[0]), .fall_o(fall[0]), .busy_o(busy[0])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(gcnt[0])
`endif
  );

  debounce #(.StableCycles(1), .ResetLevel(1'b0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din[1]),
    .level_o(level[1]), .rise_o(rise[1]), .fall_o(fall[1]), .busy_o(busy[1])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(gcnt[1])
`endif
  );

  debounce #(.StableCycles(3), .ResetLevel(1'b1)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din[2]),
    .level_o(level[2]), .rise_o(rise[2]), .fall_o(fall[2]), .busy_o(busy[2])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(gcnt[2])
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < c_ndut; i++) begin
      m_hist[i].delete();
      m_level[i]  = c_rl[i];
      m_rise[i]   = 1'b0;
      m_fall[i]   = 1'b0;
      m_glitch[i] = 0;
    end
  endtask

  task automatic model_sample(input int i, input bit s);
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (s != m_level[i]) begin
      m_hist[i].push_back(s);
      if (m_hist[i].size() >= c_n[i]) begin
        m_level[i] = s;
        m_rise[i]  = s;
        m_fall[i]  = !s;
        m_hist[i].delete();
      end
    end else begin
      if (m_hist[i].size() > 0 && m_glitch[i] < 255) m_glitch[i]++;
      m_hist[i].delete();
    end
  endtask

  task automatic check_all(input string phase);
    for (int i = 0; i < c_ndut; i++) begin
      check($sformatf("%s.level%0d", phase, i), int'(level[i]), int'(m_level[i]));
      check($sformatf("%s.rise%0d", phase, i), int'(rise[i]), int'(m_rise[i]));
      check($sformatf("%s.fall%0d", phase, i), int'(fall[i]), int'(m_fall[i]));
      check($sformatf("%s.busy%0d", phase, i), int'(busy[i]), (m_hist[i].size() > 0) ? 1 : 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check($sformatf("%s.gcnt%0d", phase, i), int'(gcnt[i]), m_glitch[i]);
`endif
    end
  endtask

  // One clock edge with per-DUT inputs; called #1 after a posedge.
  task automatic step3(input bit s0, input bit s1, input bit s2, input string phase);
    din[0] = s0;
    din[1] = s1;
    din[2] = s2;
    @(posedge clk);
    #1;
    model_sample(0, s0);
    model_sample(1, s1);
    model_sample(2, s2);
    check_all(phase);
  endtask

  task automatic step(input bit s, input string phase);
    step3(s, s, s, phase);
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model_reset();
      check_all("reset");
    end
    rst_n = 1'b1;
  endtask

  // Asynchronous reset assertion between edges, checked before any clock.
  task automatic mid_cycle_reset(input string phase);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(phase);
    @(posedge clk);
    #1;
    check_all(phase);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < c_ndut; i++) din[i] = 1'b1;
    model_reset();
    @(negedge clk);
    reset_cycles(4);

    repeat (4) step(1'b0, "settle");

    // Clean rise: dut_a must flip exactly on the 4th sampling edge.
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, "rise");
      check($sformatf("rise_lat%0d", k), int'(level[0]), (k == 4) ? 1 : 0);
      check($sformatf("rise_busy%0d", k), int'(busy[0]), (k < 4) ? 1 : 0);
    end
    check("rise_pulse", int'(rise[0]), 1);
    step(1'b1, "rise_hold");
    check("rise_once", int'(rise[0]), 0);
    repeat (4) step(1'b0, "fall");

    repeat (3) step(1'b1, "glitch");
    step(1'b0, "glitch");
    check("glitch_level", int'(level[0]), 0);
    repeat (2) step(1'b0, "glitch_tail");

    // Restart: the rise comes only at the 4th consecutive 1.
    step(1'b1, "restart"); step(1'b1, "restart"); step(1'b0, "restart");
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, "restart");
      check($sformatf("restart_lvl%0d", k), int'(level[0]), (k == 4) ? 1 : 0);
    end
    repeat (4) step(1'b0, "restart_tail");

    for (int k = 0; k < 600; k++) step(k[0], "chatter");
    check("chatter_level", int'(level[0]), 0);
    repeat (4) step(1'b0, "chatter_tail");

    step(1'b1, "midqual"); step(1'b1, "midqual");
    check("midqual_busy", int'(busy[0]), 1);
    mid_cycle_reset("midqual_rst");
    check("midqual_level", int'(level[0]), 0);

    for (int k = 0; k < 2500; k++) begin
      bit s [c_ndut];
      for (int i = 0; i < c_ndut; i++)
        s[i] = ($urandom_range(0, 3) == 0) ? !din[i] : din[i];
      step3(s[0], s[1], s[2], "rand");
      if ($urandom_range(0, 299) == 0) mid_cycle_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
